// File: rtl/graphics_pkg.sv
// Shared constants and helpers for the graphics output stage: default 640x480
// timing, colour/palette widths and the default collision layer indices.
package graphics_pkg;

  localparam int POS_W = 10;
  localparam int RGB_W = 2;
  localparam int PAL_W = 3 * RGB_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_NUM_LAYERS   = 4;
  localparam int DEF_OBST_LAYER   = 0;
  localparam int DEF_PLAYER_LAYER = 1;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running pixel/line counters with raw (unregistered) syncs, active-area
// flag and the start-of-frame tick.
module vga_timing
  import graphics_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             tick_frame
);

  localparam logic [POS_W-1:0] H_LAST    = POS_W'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [POS_W-1:0] V_LAST    = POS_W'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [POS_W-1:0] H_SS      = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] H_SE      = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] V_SS      = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] V_SE      = POS_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [POS_W-1:0] H_VISIBLE = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_VISIBLE = POS_W'(V_ACTIVE);

  logic [POS_W-1:0] hpos_r;
  logic [POS_W-1:0] vpos_r;

  // Pixel and line counters; vpos steps when hpos wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos_r <= '0;
      vpos_r <= '0;
    end else if (hpos_r == H_LAST) begin
      hpos_r <= '0;
      vpos_r <= (vpos_r == V_LAST) ? '0 : vpos_r + POS_W'(1);
    end else begin
      hpos_r <= hpos_r + POS_W'(1);
    end
  end

  // Raw active-low syncs, active area and frame tick decoded from the counters
  always_comb begin
    hpos       = hpos_r;
    vpos       = vpos_r;
    hsync      = !((hpos_r >= H_SS) && (hpos_r < H_SE));
    vsync      = !((vpos_r >= V_SS) && (vpos_r < V_SE));
    display_on = (hpos_r < H_VISIBLE) && (vpos_r < V_VISIBLE);
    tick_frame = (hpos_r == '0) && (vpos_r == '0);
  end

endmodule

// File: rtl/graphics_compositor.sv
// VGA output stage: priority compositor over NUM_LAYERS palette layers, with
// sync/blank aligned to RGB, per-pixel and per-frame collision, and game ticks.
module graphics_compositor
  import graphics_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int NUM_LAYERS   = DEF_NUM_LAYERS,
  parameter int CONV         = 0,
  parameter int TICK_DIV     = 3,
  parameter int OBST_LAYER   = DEF_OBST_LAYER,
  parameter int PLAYER_LAYER = DEF_PLAYER_LAYER,
  parameter int FRAME_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LAYERS-1:0]       i_layer,
  input  logic [PAL_W*NUM_LAYERS-1:0] i_palette,
  output logic                        o_hsync,
  output logic                        o_vsync,
  output logic [RGB_W-1:0]            o_red,
  output logic [RGB_W-1:0]            o_green,
  output logic [RGB_W-1:0]            o_blue,
  output logic                        o_display_on,
  output logic [POS_W-1-CONV:0]       o_hpos,
  output logic [POS_W-1-CONV:0]       o_vpos,
  output logic                        o_tick_frame,
  output logic                        o_tick_slow,
  output logic                        o_tick_slow_r,
  output logic                        o_collision,
  output logic                        o_collision_prev,
  output logic [FRAME_W-1:0]          o_frame_count
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("graphics_compositor: TICK_DIV must be at least 1");
  end
  if (NUM_LAYERS < 2) begin : g_bad_num_layers
    $error("graphics_compositor: NUM_LAYERS must be at least 2");
  end
  if (OBST_LAYER == PLAYER_LAYER) begin : g_bad_layers
    $error("graphics_compositor: OBST_LAYER and PLAYER_LAYER must differ");
  end

  logic [POS_W-1:0]   hpos_s;
  logic [POS_W-1:0]   vpos_s;
  logic               hsync_s;
  logic               vsync_s;
  logic               display_on_s;
  logic               tick_frame_s;
  logic               tick_slow_s;
  logic               collision_s;
  logic [PAL_W-1:0]   colour_s;
  logic               latch_r;
  logic [DIV_W-1:0]   div_r;
  logic [FRAME_W-1:0] frame_count_r;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .hpos       (hpos_s),
    .vpos       (vpos_s),
    .hsync      (hsync_s),
    .vsync      (vsync_s),
    .display_on (display_on_s),
    .tick_frame (tick_frame_s)
  );

  // Scan from the lowest priority upward so the lowest set index wins; blank outside the active area
  always_comb begin
    colour_s = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      colour_s = i_layer[k] ? i_palette[PAL_W*k +: PAL_W] : colour_s;
    end
    colour_s    = display_on_s ? colour_s : '0;
    collision_s = display_on_s && i_layer[OBST_LAYER] && i_layer[PLAYER_LAYER];
    tick_slow_s = tick_frame_s && (div_r == DIV_LAST);
  end

  assign o_hpos        = hpos_s[POS_W-1:CONV];
  assign o_vpos        = vpos_s[POS_W-1:CONV];
  assign o_tick_frame  = tick_frame_s;
  assign o_tick_slow   = tick_slow_s;
  assign o_frame_count = frame_count_r;

  // Output stage: video and collision describe the pixel sampled on this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_hsync                    <= 1'b1;
      o_vsync                    <= 1'b1;
      o_display_on               <= 1'b0;
      {o_red, o_green, o_blue}   <= '0;
      o_collision                <= 1'b0;
      o_tick_slow_r              <= 1'b0;
    end else begin
      o_hsync                    <= hsync_s;
      o_vsync                    <= vsync_s;
      o_display_on               <= display_on_s;
      {o_red, o_green, o_blue}   <= colour_s;
      o_collision                <= collision_s;
      o_tick_slow_r              <= tick_slow_s;
    end
  end

  // Per-frame collision latch; the frame tick hands the finished frame to o_collision_prev
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_r          <= 1'b0;
      o_collision_prev <= 1'b0;
    end else if (tick_frame_s) begin
      latch_r          <= collision_s;
      o_collision_prev <= latch_r;
    end else begin
      latch_r          <= latch_r | collision_s;
    end
  end

  // Slow-tick divider and frame counter, both stepped by the frame tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r         <= '0;
      frame_count_r <= '0;
    end else if (tick_frame_s) begin
      div_r         <= (div_r == DIV_LAST) ? '0 : div_r + DIV_W'(1);
      frame_count_r <= frame_count_r + FRAME_W'(1);
    end else begin
      div_r         <= div_r;
      frame_count_r <= frame_count_r;
    end
  end

endmodule

// File: tb/tb_graphics_compositor.sv
// Scoreboard bench: a default 640x480 instance for compositing and line timing,
// two reduced-timing instances for frame ticks, collision, mid-frame reset and counter wrap.
module tb_graphics_compositor;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48, VA = 480, VF = 10, VS = 2, VB = 33;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  localparam int SHA = 8, SHF = 1, SHS = 2, SHB = 1, SVA = 4, SVF = 1, SVS = 1, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB, SVT = SVA + SVF + SVS + SVB;
  localparam int SFRAME = SHT * SVT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance
  logic rst_d, hs_d, vs_d, de_d, tf_d, ts_d, tsr_d, col_d, colp_d;
  logic [3:0] lay_d;
  logic [23:0] pal_d;
  logic [1:0] r_d, g_d, b_d;
  logic [9:0] hpos_d, vpos_d;
  logic [7:0] fc_d;
  // small-timing instance, TICK_DIV=3
  logic rst_s, hs_s, vs_s, de_s, tf_s, ts_s, tsr_s, col_s, colp_s;
  logic [3:0] lay_s;
  logic [23:0] pal_s;
  logic [1:0] r_s, g_s, b_s;
  logic [9:0] hpos_s, vpos_s;
  logic [7:0] fc_s;
  // small-timing instance, TICK_DIV=1, FRAME_W=2
  logic rst_w, hs_w, vs_w, de_w, tf_w, ts_w, tsr_w, col_w, colp_w;
  logic [3:0] lay_w;
  logic [23:0] pal_w;
  logic [1:0] r_w, g_w, b_w;
  logic [9:0] hpos_w, vpos_w;
  logic [1:0] fc_w;

  graphics_compositor dut (
    .clk(clk), .rst(rst_d), .i_layer(lay_d), .i_palette(pal_d),
    .o_hsync(hs_d), .o_vsync(vs_d), .o_red(r_d), .o_green(g_d), .o_blue(b_d),
    .o_display_on(de_d), .o_hpos(hpos_d), .o_vpos(vpos_d), .o_tick_frame(tf_d),
    .o_tick_slow(ts_d), .o_tick_slow_r(tsr_d), .o_collision(col_d),
    .o_collision_prev(colp_d), .o_frame_count(fc_d)
  );

  graphics_compositor #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .TICK_DIV(3), .FRAME_W(8)
  ) dut_s (
    .clk(clk), .rst(rst_s), .i_layer(lay_s), .i_palette(pal_s),
    .o_hsync(hs_s), .o_vsync(vs_s), .o_red(r_s), .o_green(g_s), .o_blue(b_s),
    .o_display_on(de_s), .o_hpos(hpos_s), .o_vpos(vpos_s), .o_tick_frame(tf_s),
    .o_tick_slow(ts_s), .o_tick_slow_r(tsr_s), .o_collision(col_s),
    .o_collision_prev(colp_s), .o_frame_count(fc_s)
  );

  graphics_compositor #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .TICK_DIV(1), .FRAME_W(2)
  ) dut_w (
    .clk(clk), .rst(rst_w), .i_layer(lay_w), .i_palette(pal_w),
    .o_hsync(hs_w), .o_vsync(vs_w), .o_red(r_w), .o_green(g_w), .o_blue(b_w),
    .o_display_on(de_w), .o_hpos(hpos_w), .o_vpos(vpos_w), .o_tick_frame(tf_w),
    .o_tick_slow(ts_w), .o_tick_slow_r(tsr_w), .o_collision(col_w),
    .o_collision_prev(colp_w), .o_frame_count(fc_w)
  );

  // Reference pixel: {hsync, vsync, display_on, rgb[5:0], collision}
  function automatic logic [9:0] pix_model(input int h, input int v, input int ha, input int hf,
                                            input int hsw, input int va, input int vf, input int vsw,
                                            input logic [3:0] lay, input logic [23:0] pal);
    logic hs, vs, de, col, found;
    logic [5:0] rgb;
    hs = !(h >= ha + hf && h < ha + hf + hsw);
    vs = !(v >= va + vf && v < va + vf + vsw);
    de = (h < ha) && (v < va);
    rgb = 6'b0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (lay[k] && !found) begin
        rgb = pal[6*k +: 6];
        found = 1'b1;
      end
    end
    if (!de) rgb = 6'b0;
    col = de && lay[0] && lay[1];
    return {hs, vs, de, rgb, col};
  endfunction

  logic [9:0] q_d[$];
  logic [9:0] q_s[$];
  logic [1:0] q_w[$];
  int mh, mv, sh, sv, ntick;
  logic m_latch, m_prev, m_slow_prev;

  // One default-instance pixel: retire the previous expectation, drive and queue this one
  task automatic d_cycle(input logic [3:0] lay, input logic [23:0] pal);
    logic [9:0] got, exp;
    if (q_d.size() > 0) begin
      exp = q_d.pop_front();
      got = {hs_d, vs_d, de_d, r_d, g_d, b_d, col_d};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL d_pixel before (%0d,%0d): got %b expected %b", mh, mv, got, exp);
      end
    end
    checks++;
    if (hpos_d !== 10'(mh) || vpos_d !== 10'(mv)) begin
      errors++;
      $display("FAIL d_pos: got (%0d,%0d) expected (%0d,%0d)", hpos_d, vpos_d, mh, mv);
    end
    lay_d = lay;
    pal_d = pal;
    q_d.push_back(pix_model(mh, mv, HA, HF, HS, VA, VF, VS, lay, pal));
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
    @(negedge clk);
  endtask

  task automatic s_reset_model();
    sh = 0; sv = 0; ntick = 0;
    m_latch = 1'b0; m_prev = 1'b0; m_slow_prev = 1'b0;
    q_s.delete();
  endtask

  // One small-instance pixel: pixel scoreboard plus tick/frame/collision-latch model
  task automatic s_cycle(input logic [3:0] lay);
    logic [9:0] got, exp;
    logic [11:0] tg, te;
    logic tick, slow;
    if (q_s.size() > 0) begin
      exp = q_s.pop_front();
      got = {hs_s, vs_s, de_s, r_s, g_s, b_s, col_s};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL s_pixel before (%0d,%0d): got %b expected %b", sh, sv, got, exp);
      end
    end
    tick = (sh == 0 && sv == 0);
    slow = tick && (ntick % 3 == 2);
    te = {tick, slow, m_slow_prev, m_prev, 8'(ntick)};
    tg = {tf_s, ts_s, tsr_s, colp_s, fc_s};
    checks++;
    if (tg !== te || hpos_s !== 10'(sh) || vpos_s !== 10'(sv)) begin
      errors++;
      $display("FAIL s_ticks at (%0d,%0d): got %h pos (%0d,%0d) expected %h", sh, sv, tg, hpos_s, vpos_s, te);
    end
    lay_s = lay;
    exp = pix_model(sh, sv, SHA, SHF, SHS, SVA, SVF, SVS, lay, pal_s);
    q_s.push_back(exp);
    if (tick) begin
      m_prev = m_latch;
      m_latch = exp[0];
      ntick++;
    end else begin
      m_latch = m_latch | exp[0];
    end
    m_slow_prev = slow;
    sh++;
    if (sh == SHT) begin
      sh = 0;
      sv = (sv == SVT - 1) ? 0 : sv + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [29:0] got;
    repeat (3) @(negedge clk);
    got = {hs_d, vs_d, de_d, r_d, g_d, b_d, col_d, colp_d, tsr_d, ts_d, fc_d, hpos_d[3:0], vpos_d[3:0], tf_d};
    checks++;
    if (got !== {1'b1, 1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got %b", got);
    end
    rst_d = 1'b0;
    mh = 0; mv = 0;
    checks++;
    if (tf_d !== 1'b1) begin
      errors++;
      $display("FAIL first_tick: got %b expected 1", tf_d);
    end
    d_cycle(4'b0000, 24'h0);
    checks++;
    if (tf_d !== 1'b0) begin
      errors++;
      $display("FAIL tick_after_first: got %b expected 0", tf_d);
    end
  endtask

  task automatic test_composite();
    logic [23:0] pal;
    pal = {6'b101010, 6'b000011, 6'b110000, 6'b111111};
    d_cycle(4'b0110, pal);
    checks++;
    if ({r_d, g_d, b_d} !== 6'b110000) begin
      errors++;
      $display("FAIL composite_active: got %b expected 110000", {r_d, g_d, b_d});
    end
    while (mh < 700) d_cycle(4'($urandom_range(0, 15)), 24'($urandom));
    d_cycle(4'b0110, pal);
    checks++;
    if ({r_d, g_d, b_d} !== 6'b000000) begin
      errors++;
      $display("FAIL composite_hblank: got %b expected 000000", {r_d, g_d, b_d});
    end
  endtask

  task automatic test_hsync();
    int first, low, line_v;
    while (mh != 0) d_cycle(4'($urandom_range(0, 15)), 24'($urandom));
    first = -1; low = 0; line_v = mv;
    for (int k = 0; k < HT; k++) begin
      if (!hs_d) begin
        if (first < 0) first = k;
        low++;
      end
      d_cycle(4'($urandom_range(0, 15)), 24'($urandom));
    end
    checks++;
    if (first != 657 || low != 96) begin
      errors++;
      $display("FAIL hsync_window: got start %0d width %0d expected start 657 width 96", first, low);
    end
    checks++;
    if (hpos_d !== 10'd0 || vpos_d !== 10'(line_v + 1)) begin
      errors++;
      $display("FAIL line_period: got (%0d,%0d) expected (0,%0d)", hpos_d, vpos_d, line_v + 1);
    end
  endtask

  task automatic test_ticks();
    logic [9:0] slow_mask;
    int t, last, nslow_r;
    rst_s = 1'b0;
    s_reset_model();
    slow_mask = '0; t = 0; last = 0; nslow_r = 0;
    for (int c = 0; c < 9 * SFRAME; c++) begin
      if (tf_s) begin
        t++;
        if (t > 1) begin
          checks++;
          if (c - last != SFRAME) begin
            errors++;
            $display("FAIL frame_period: got %0d expected %0d", c - last, SFRAME);
          end
        end
        last = c;
      end
      if (ts_s && t < 10) slow_mask[t] = 1'b1;
      if (tsr_s) nslow_r++;
      s_cycle(4'($urandom_range(0, 15)));
    end
    checks++;
    if (slow_mask !== 10'b1001001000 || nslow_r != 3 || fc_s !== 8'd9) begin
      errors++;
      $display("FAIL slow_ticks: got mask %b slow_r %0d count %0d expected 1001001000 3 9", slow_mask, nslow_r, fc_s);
    end
  endtask

  task automatic test_collision();
    while (!(sh == 3 && sv == 2)) s_cycle(4'b0000);
    s_cycle(4'b0011);
    checks++;
    if (col_s !== 1'b1) begin
      errors++;
      $display("FAIL collision_pulse: got %b expected 1", col_s);
    end
    s_cycle(4'b0000);
    checks++;
    if (col_s !== 1'b0) begin
      errors++;
      $display("FAIL collision_clear: got %b expected 0", col_s);
    end
    while (!(sh == 0 && sv == 0)) s_cycle(4'b0000);
    s_cycle(4'b0000);
    checks++;
    if (colp_s !== 1'b1) begin
      errors++;
      $display("FAIL collision_prev_set: got %b expected 1", colp_s);
    end
    while (!(sh == 0 && sv == 0)) s_cycle(4'b0000);
    s_cycle(4'b0000);
    checks++;
    if (colp_s !== 1'b0) begin
      errors++;
      $display("FAIL collision_prev_clear: got %b expected 0", colp_s);
    end
  endtask

  task automatic test_mid_reset();
    logic [33:0] got;
    while (!(sh == 5 && sv == 2)) s_cycle(4'b0011);
    rst_s = 1'b1;
    #1;
    got = {hs_s, vs_s, de_s, r_s, g_s, b_s, col_s, colp_s, tsr_s, ts_s, fc_s, hpos_s, tf_s};
    checks++;
    if (got !== {1'b1, 1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0, 1'b1} || vpos_s !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_state: got %b vpos %0d", got, vpos_s);
    end
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    s_reset_model();
    for (int c = 0; c < 2 * SFRAME; c++) s_cycle(4'($urandom_range(0, 15)));
  endtask

  task automatic test_frame_wrap();
    int wh, wv, nt;
    logic pend, tick;
    logic [1:0] exp;
    logic [9:0] seq;
    rst_w = 1'b0;
    wh = 0; wv = 0; nt = 0; pend = 1'b0; seq = '0;
    q_w.delete();
    for (int c = 0; c <= 4 * SFRAME + 1; c++) begin
      if (pend) begin
        exp = q_w.pop_front();
        seq = {seq[7:0], fc_w};
        checks++;
        if (fc_w !== exp) begin
          errors++;
          $display("FAIL frame_count_wrap: got %0d expected %0d", fc_w, exp);
        end
        pend = 1'b0;
      end
      tick = (wh == 0 && wv == 0);
      checks++;
      if (tf_w !== tick || ts_w !== tick || hpos_w !== 10'(wh)) begin
        errors++;
        $display("FAIL w_tick: got frame %b slow %b hpos %0d expected %b %b %0d", tf_w, ts_w, hpos_w, tick, tick, wh);
      end
      if (tick) begin
        q_w.push_back(2'(nt + 1));
        nt++;
        pend = 1'b1;
      end
      wh++;
      if (wh == SHT) begin
        wh = 0;
        wv = (wv == SVT - 1) ? 0 : wv + 1;
      end
      @(negedge clk);
    end
    checks++;
    if (seq !== 10'b01_10_11_00_01) begin
      errors++;
      $display("FAIL frame_count_seq: got %b expected 0110110001", seq);
    end
  endtask

  initial begin
    rst_d = 1'b1; rst_s = 1'b1; rst_w = 1'b1;
    lay_d = '0; lay_s = '0; lay_w = 4'b0011;
    pal_d = '0; pal_w = 24'hABCDEF;
    pal_s = {6'b010101, 6'b101010, 6'b001100, 6'b110011};
    mh = 0; mv = 0;
    s_reset_model();
    test_reset();
    test_composite();
    test_hsync();
    test_ticks();
    test_collision();
    test_mid_reset();
    test_frame_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
